conv_mac_14: RTL and testbench
==============================

CONV_MAC_14 -- requirements
Module: conv_mac_14

Interface
REQ-001 Parameter COEFF_W, default 16, signed weight width; SHALL match the width of the weight stream produced by the layer-14 weight source.
REQ-002 Parameter DATA_W, default 16, signed pixel width.
REQ-003 Parameter ACC_W, default 40, signed accumulator and result width; SHALL be at least COEFF_W+DATA_W.
REQ-004 Parameter KERN_LEN, default 9, number of weight/pixel pairs per output; legal range 1..65535.
REQ-005 ap_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-007 weight_V_dout  in  COEFF_W  head of the weight FIFO.
REQ-008 weight_V_empty_n  in  1  weight FIFO holds data.
REQ-009 weight_V_read  out  1  pop the weight FIFO this cycle.
REQ-010 pixel_V_dout  in  DATA_W  head of the pixel FIFO.
REQ-011 pixel_V_empty_n  in  1  pixel FIFO holds data.
REQ-012 pixel_V_read  out  1  pop the pixel FIFO this cycle.
REQ-013 output_V_din  out  ACC_W  accumulated dot-product result.
REQ-014 output_V_full_n  in  1  output FIFO can accept a word.
REQ-015 output_V_write  out  1  push output_V_din this cycle.

Function
REQ-016 Two states: ACCUM and EMIT; reset state is ACCUM.
REQ-017 In ACCUM, weight_V_read and pixel_V_read SHALL both equal weight_V_empty_n AND pixel_V_empty_n (combinational); the two streams are always popped together, never singly.
REQ-018 In EMIT, both read strobes SHALL be 0 regardless of FIFO status.
REQ-019 Each pop (a "beat") SHALL form the full-precision signed product weight*pixel, sign-extend it to ACC_W, and add it to the accumulator; addition wraps modulo 2^ACC_W with no saturation.
REQ-020 A beat counter SHALL run 0..KERN_LEN-1, increment on each beat, and wrap to 0 on the last beat.
REQ-021 On the last beat (counter = KERN_LEN-1), the result register SHALL load accumulator + product of that beat, the accumulator SHALL clear to 0, and the state SHALL move to EMIT.
REQ-022 In EMIT, output_V_write SHALL equal output_V_full_n; output_V_din SHALL hold the result register constant for the whole of EMIT.
REQ-023 In EMIT with output_V_full_n=1, the write SHALL complete that cycle and the state SHALL return to ACCUM; with output_V_full_n=0 the block SHALL hold EMIT indefinitely.
REQ-024 Latency: if the last beat occurs in cycle t, output_V_write SHALL be asserted earliest in cycle t+1.
REQ-025 Peak throughput: one result per KERN_LEN+1 cycles.
REQ-026 A cycle in ACCUM where either empty_n is 0 SHALL be a stall: accumulator and counter unchanged.
REQ-027 For KERN_LEN=1, every beat is a last beat; each beat is followed by one EMIT cycle.
REQ-028 output_V_write SHALL never be asserted in ACCUM, and no read strobe SHALL coincide with output_V_write.

Reset
REQ-029 While ap_rst_n=0 (asynchronously, including mid-operation): state=ACCUM, accumulator=0, counter=0, result register=0, output_V_write=0, output_V_din=0; read strobes follow REQ-017 combinationally.
REQ-030 A partial accumulation or pending EMIT interrupted by reset SHALL be discarded and never written.

Verification
REQ-031 KERN_LEN=9, both FIFOs always non-empty, weights all 1, pixels 1..9, full_n=1 -> reads high 9 cycles, then one write with din=45, then repeat with period 10.
REQ-032 KERN_LEN=4, weights {-32768,-32768,-32768,-32768}, pixels all -32768 -> din=4*2^30=4294967296 (no overflow at ACC_W=40).
REQ-033 Pixel FIFO empty on alternate cycles during a 9-beat kernel -> reads only on non-empty cycles, result identical to the unstalled run (45).
REQ-034 full_n=0 for 5 cycles after the last beat -> write=0 and reads=0 for those 5 cycles, din held, write asserted on the cycle full_n returns to 1, ACCUM resumes next cycle.
REQ-035 ap_rst_n pulsed low after beat 5 of 9 -> outputs zero immediately; the next 9 beats produce din equal to the sum of only those beats.
REQ-036 KERN_LEN=1, weight=3, pixel=-7 streaming -> alternating read/write cycles, din=-21 each write.

Source files
------------

// File: rtl/conv_mac_14.sv
// conv_mac_14: streaming multiply-accumulate for one layer-14 convolution output.
// Weight and pixel FIFOs are popped together, one pair per beat. KERN_LEN beats
// accumulate into a full-precision signed sum. That sum is then offered to the
// output FIFO for one or more EMIT cycles before accumulation resumes.
module conv_mac_14 #(
  parameter int COEFF_W  = 16,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int KERN_LEN = 9
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COEFF_W-1:0] weight_V_dout,
  input  logic               weight_V_empty_n,
  output logic               weight_V_read,
  input  logic [DATA_W-1:0]  pixel_V_dout,
  input  logic               pixel_V_empty_n,
  output logic               pixel_V_read,
  output logic [ACC_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int PROD_W = COEFF_W + DATA_W;
  localparam int CNT_W  = (KERN_LEN > 1) ? $clog2(KERN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KERN_LEN - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  // Widen a full-precision product to accumulator width, preserving its sign.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    sext_prod = ACC_W'(p);
  endfunction

  // Accumulator add. It wraps modulo 2^ACC_W with no saturation.
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    wrap_add = a + b;
  endfunction

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] result;
  logic [CNT_W-1:0]        cnt;

  logic signed [COEFF_W-1:0] weight_p0;
  logic signed [DATA_W-1:0]  pixel_p0;
  logic signed [PROD_W-1:0]  weight_ext_p0;
  logic signed [PROD_W-1:0]  pixel_ext_p0;
  logic signed [PROD_W-1:0]  prod_full_p0;
  logic signed [ACC_W-1:0]   prod_p0;
  logic signed [ACC_W-1:0]   sum_p0;
  logic                      vld_p0;
  logic                      last_p0;

  // ---- stage p0: beat qualification and product of the FIFO heads ----
  // Form the beat strobe and the running sum that includes this beat's product.
  always_comb begin
    weight_p0     = $signed(weight_V_dout);
    pixel_p0      = $signed(pixel_V_dout);
    weight_ext_p0 = PROD_W'(weight_p0);
    pixel_ext_p0  = PROD_W'(pixel_p0);
    prod_full_p0  = weight_ext_p0 * pixel_ext_p0;
    prod_p0       = sext_prod(prod_full_p0);
    sum_p0        = wrap_add(acc, prod_p0);
    vld_p0        = (state == ACCUM) && weight_V_empty_n && pixel_V_empty_n;
    last_p0       = vld_p0 && (cnt == LAST_BEAT);
  end

  // Both streams are popped on the same beat, so one strobe drives both.
  assign weight_V_read = vld_p0;
  assign pixel_V_read  = vld_p0;

  // The result register is presented for the whole EMIT phase.
  assign output_V_write = (state == EMIT) && output_V_full_n;
  assign output_V_din   = result;

  // ---- stage p1: registered accumulation state ----
  // Sequence ACCUM/EMIT and count beats within the current kernel.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (vld_p0) begin
            if (last_p0) begin
              cnt   <= '0;
              state <= EMIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (output_V_full_n) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Accumulate each beat, then on the last beat move the final sum into result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc    <= '0;
      result <= '0;
    end else if (vld_p0) begin
      if (last_p0) begin
        result <= sum_p0;
        acc    <= '0;
      end else begin
        acc <= sum_p0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_14.sv
// Bench for conv_mac_14. It uses three instances (KERN_LEN 9, 4 and 1).
// A behavioural model collects beat products and sums each completed kernel.
// A per-cycle compare process checks it against every instance.
// Directed phases add literal expectations for the documented scenarios.
module tb_conv_mac_14;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [15:0] w [3];
  logic signed [15:0] p [3];
  logic we_n [3];
  logic pe_n [3];
  logic full_n [3];
  logic rd_w [3];
  logic rd_p [3];
  logic wr [3];
  logic [39:0] din [3];

  int kl [3] = '{9, 4, 1};

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // model state: products of the kernel in progress, and the pending result
  longint      beats_q [3][$];
  bit          emit_m [3];
  logic [39:0] res_m [3];
  logic        exp_rd, exp_wr;
  longint      s;

  // observations used by the literal checks
  logic [39:0] last_wr [3];
  int          nwr [3];
  int          last_wc [3];
  int          prev_wc [3];

  // stimulus queues for the active stream
  int wq [$];
  int pq [$];

  always #5 clk = ~clk;

  conv_mac_14 #(.KERN_LEN(9)) u0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .weight_V_dout(w[0]), .weight_V_empty_n(we_n[0]), .weight_V_read(rd_w[0]),
    .pixel_V_dout(p[0]), .pixel_V_empty_n(pe_n[0]), .pixel_V_read(rd_p[0]),
    .output_V_din(din[0]), .output_V_full_n(full_n[0]), .output_V_write(wr[0]));

  conv_mac_14 #(.KERN_LEN(4)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .weight_V_dout(w[1]), .weight_V_empty_n(we_n[1]), .weight_V_read(rd_w[1]),
    .pixel_V_dout(p[1]), .pixel_V_empty_n(pe_n[1]), .pixel_V_read(rd_p[1]),
    .output_V_din(din[1]), .output_V_full_n(full_n[1]), .output_V_write(wr[1]));

  conv_mac_14 #(.KERN_LEN(1)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .weight_V_dout(w[2]), .weight_V_empty_n(we_n[2]), .weight_V_read(rd_w[2]),
    .pixel_V_dout(p[2]), .pixel_V_empty_n(pe_n[2]), .pixel_V_read(rd_p[2]),
    .output_V_din(din[2]), .output_V_full_n(full_n[2]), .output_V_write(wr[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled at the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        beats_q[i].delete();
        emit_m[i] = 1'b0;
        res_m[i]  = '0;
        chk($sformatf("rst_wr%0d", i), 64'(wr[i]), 64'(0));
        chk($sformatf("rst_din%0d", i), 64'(din[i]), 64'(0));
        chk($sformatf("rst_rdw%0d", i), 64'(rd_w[i]), 64'(we_n[i] & pe_n[i]));
        chk($sformatf("rst_rdp%0d", i), 64'(rd_p[i]), 64'(we_n[i] & pe_n[i]));
      end else begin
        exp_rd = !emit_m[i] && we_n[i] && pe_n[i];
        exp_wr = emit_m[i] && full_n[i];
        chk($sformatf("rdw%0d", i), 64'(rd_w[i]), 64'(exp_rd));
        chk($sformatf("rdp%0d", i), 64'(rd_p[i]), 64'(exp_rd));
        chk($sformatf("wr%0d", i), 64'(wr[i]), 64'(exp_wr));
        if (emit_m[i]) chk($sformatf("din%0d", i), 64'(din[i]), 64'(res_m[i]));
        if (wr[i] === 1'b1) begin
          prev_wc[i] = last_wc[i];
          last_wc[i] = cyc;
          last_wr[i] = din[i];
          nwr[i]++;
        end
        if (exp_rd) begin
          beats_q[i].push_back(longint'(w[i]) * longint'(p[i]));
          if (beats_q[i].size() == kl[i]) begin
            s = 0;
            foreach (beats_q[i][k]) s += beats_q[i][k];
            res_m[i]  = s[39:0];
            beats_q[i].delete();
            emit_m[i] = 1'b1;
          end
        end else if (exp_wr) begin
          emit_m[i] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present wq/pq as FIFO contents to instance i, popping when the DUT reads.
  task automatic run_stream(input int i, input bit gap, input int budget);
    int k = 0;
    int c = 0;
    bit popped;
    while (k < wq.size() && c < budget) begin
      w[i]    = 16'(wq[k]);
      p[i]    = 16'(pq[k]);
      we_n[i] = 1'b1;
      pe_n[i] = (gap && (c % 2 == 1)) ? 1'b0 : 1'b1;
      @(negedge clk);
      popped = rd_w[i];
      step();
      if (popped === 1'b1) k++;
      c++;
    end
    we_n[i] = 1'b0;
    pe_n[i] = 1'b0;
    if (k < wq.size()) chk("stream_timeout", 64'(k), 64'(wq.size()));
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = '0; p[i] = '0; we_n[i] = 1'b0; pe_n[i] = 1'b0; full_n[i] = 1'b1;
      nwr[i] = 0; last_wc[i] = 0; prev_wc[i] = 0; last_wr[i] = '0;
    end
    // reset: outputs zero, read strobes follow the FIFO flags combinationally
    we_n[0] = 1'b1; pe_n[0] = 1'b1;
    step(); step();
    chk("reset_din", 64'(din[0]), 64'(0));
    chk("reset_wr", 64'(wr[0]), 64'(0));
    chk("reset_rd_comb", 64'(rd_w[0]), 64'(1));
    we_n[0] = 1'b0; pe_n[0] = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // two back-to-back kernels, weights 1, pixels 1..9
    wq.delete(); pq.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 9; k++) begin wq.push_back(1); pq.push_back(k); end
    run_stream(0, 1'b0, 100);
    step(); step();
    chk("basic_nwr", 64'(nwr[0]), 64'(2));
    chk("basic_din", 64'(last_wr[0]), 64'(45));
    chk("basic_period", 64'(last_wc[0] - prev_wc[0]), 64'(10));

    // pixel FIFO empty on alternate cycles
    base = nwr[0];
    wq.delete(); pq.delete();
    for (int k = 1; k <= 9; k++) begin wq.push_back(1); pq.push_back(k); end
    run_stream(0, 1'b1, 100);
    step(); step();
    chk("stall_nwr", 64'(nwr[0] - base), 64'(1));
    chk("stall_din", 64'(last_wr[0]), 64'(45));

    // output backpressure for 5 cycles after the last beat
    base = nwr[0];
    full_n[0] = 1'b0;
    wq.delete(); pq.delete();
    for (int k = 1; k <= 9; k++) begin wq.push_back(2); pq.push_back(k); end
    run_stream(0, 1'b0, 100);
    w[0] = 16'sd5; p[0] = 16'sd5; we_n[0] = 1'b1; pe_n[0] = 1'b1;
    for (int h = 0; h < 5; h++) begin
      chk("hold_wr", 64'(wr[0]), 64'(0));
      chk("hold_rd", 64'(rd_w[0]), 64'(0));
      chk("hold_din", 64'(din[0]), 64'(90));
      step();
    end
    we_n[0] = 1'b0; pe_n[0] = 1'b0; full_n[0] = 1'b1;
    #1;
    chk("bp_write_on_return", 64'(wr[0]), 64'(1));
    step(); step();
    chk("bp_nwr", 64'(nwr[0] - base), 64'(1));
    chk("bp_din", 64'(last_wr[0]), 64'(90));

    // reset after beat 5 of 9 discards the partial sum
    wq.delete(); pq.delete();
    for (int k = 1; k <= 5; k++) begin wq.push_back(1); pq.push_back(k); end
    run_stream(0, 1'b0, 40);
    base = nwr[0];
    rst_n = 1'b0;
    #1;
    chk("midrst_din", 64'(din[0]), 64'(0));
    chk("midrst_wr", 64'(wr[0]), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    wq.delete(); pq.delete();
    for (int k = 10; k <= 18; k++) begin wq.push_back(1); pq.push_back(k); end
    run_stream(0, 1'b0, 100);
    step(); step();
    chk("midrst_nwr", 64'(nwr[0] - base), 64'(1));
    chk("midrst_sum", 64'(last_wr[0]), 64'(126));

    // KERN_LEN=4 extreme negative operands
    wq.delete(); pq.delete();
    for (int k = 0; k < 4; k++) begin wq.push_back(-32768); pq.push_back(-32768); end
    run_stream(1, 1'b0, 40);
    step(); step();
    chk("k4_nwr", 64'(nwr[1]), 64'(1));
    chk("k4_din", 64'(last_wr[1]), 64'h01_0000_0000);

    // KERN_LEN=1 alternating read/write, 3 * -7
    wq.delete(); pq.delete();
    for (int k = 0; k < 4; k++) begin wq.push_back(3); pq.push_back(-7); end
    run_stream(2, 1'b0, 40);
    step(); step();
    chk("k1_nwr", 64'(nwr[2]), 64'(4));
    chk("k1_din", 64'(last_wr[2]), 64'hFF_FFFF_FFEB);
    chk("k1_spacing", 64'(last_wc[2] - prev_wc[2]), 64'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
